gpr_write_arbiter: RTL and testbench

- Shares the register file's single write port between two write-back sources.
- Requester 0 is the main pipeline write-back; requester 1 is a secondary completer, e.g. the multiply/divide unit or a load-return path.
- Registers the winning write for one cycle, drives the GPR write port (WE/RW/WD plus pc for the write trace), and offers a same-cycle bypass of the in-flight write to read-address queries.
- Sits directly in front of the GPR.

---
 rtl/gpr_write_arbiter.sv | 131 +++++++++++++
 tb/tb_gpr_write_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter: shares the single GPR write port between the main
// pipeline write-back (requester 0) and a secondary completer (requester 1).
// Requester 0 has priority; requester 1 is force-granted after losing
// STARVE_LIMIT consecutive cycles. The winning write is registered for one
// cycle and also exposed to two read-address bypass queries.
module gpr_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic [31:0] req0_pc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    input  logic [31:0] req1_pc,
    output logic        gpr_we,
    output logic [4:0]  gpr_rw,
    output logic [31:0] gpr_wd,
    output logic [31:0] gpr_pc,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_hit,
    output logic        rt_hit,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        grant_last
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic             gnt0_s;
    logic             gnt1_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             gpr_we_r;
    logic [4:0]       gpr_rw_r;
    logic [31:0]      gpr_wd_r;
    logic [31:0]      gpr_pc_r;
    logic             grant_last_r;

    // Grant selection: requester 0 wins ties unless requester 1 has starved.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (starve_cnt_r == LIMIT_C) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (req0_valid) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Readies are suppressed while reset is held so no handshake completes.
    assign req0_ready = gnt0_s & reset;
    assign req1_ready = gnt1_s & reset;

    // Starvation counter next value: counts consecutive losses by requester 1.
    always_comb begin
        cnt_nxt_s = starve_cnt_r;
        if (!req1_valid || gnt1_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (starve_cnt_r >= LIMIT_C) begin
            cnt_nxt_s = LIMIT_C;
        end else begin
            cnt_nxt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= cnt_nxt_s;
        end
    end

    // Output stage: capture the winning write; writes to $0 never enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpr_we_r     <= 1'b0;
            gpr_rw_r     <= 5'd0;
            gpr_wd_r     <= 32'd0;
            gpr_pc_r     <= 32'd0;
            grant_last_r <= 1'b0;
        end else if (gnt1_s) begin
            gpr_we_r     <= (req1_addr != 5'd0);
            gpr_rw_r     <= req1_addr;
            gpr_wd_r     <= req1_data;
            gpr_pc_r     <= req1_pc;
            grant_last_r <= 1'b1;
        end else if (gnt0_s) begin
            gpr_we_r     <= (req0_addr != 5'd0);
            gpr_rw_r     <= req0_addr;
            gpr_wd_r     <= req0_data;
            gpr_pc_r     <= req0_pc;
            grant_last_r <= 1'b0;
        end else begin
            gpr_we_r     <= 1'b0;
        end
    end

    assign gpr_we     = gpr_we_r;
    assign gpr_rw     = gpr_rw_r;
    assign gpr_wd     = gpr_wd_r;
    assign gpr_pc     = gpr_pc_r;
    assign grant_last = grant_last_r;

    // Bypass of the in-flight write; $0 never hits.
    always_comb begin
        rs_hit  = gpr_we_r && (gpr_rw_r == rs_addr) && (rs_addr != 5'd0);
        rt_hit  = gpr_we_r && (gpr_rw_r == rt_addr) && (rt_addr != 5'd0);
        rs_data = rs_hit ? gpr_wd_r : 32'd0;
        rt_data = rt_hit ? gpr_wd_r : 32'd0;
    end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed self-checking bench for gpr_write_arbiter (STARVE_LIMIT = 4).
module tb_gpr_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data, req0_pc, req1_pc;
    logic        gpr_we;
    logic [4:0]  gpr_rw;
    logic [31:0] gpr_wd, gpr_pc;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_hit, rt_hit;
    logic [31:0] rs_data, rt_data;
    logic        grant_last;

    int checks_cnt;
    int errors_cnt;

    gpr_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_pc    (req0_pc),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_pc    (req1_pc),
        .gpr_we     (gpr_we),
        .gpr_rw     (gpr_rw),
        .gpr_wd     (gpr_wd),
        .gpr_pc     (gpr_pc),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_hit     (rs_hit),
        .rt_hit     (rt_hit),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .grant_last (grant_last)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0; req0_pc = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0; req1_pc = 32'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
    endtask

    int          exp_g [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [31:0] exp_wd;

    // Directed stimulus sequence.
    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        idle_inputs();
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #3;
        // Reset state: outputs cleared, readies forced low despite valids.
        check_eq("rst_we",    {31'd0, gpr_we},     32'd0);
        check_eq("rst_rw",    {27'd0, gpr_rw},     32'd0);
        check_eq("rst_wd",    gpr_wd,              32'd0);
        check_eq("rst_pc",    gpr_pc,              32'd0);
        check_eq("rst_glast", {31'd0, grant_last}, 32'd0);
        check_eq("rst_rdy0",  {31'd0, req0_ready}, 32'd0);
        check_eq("rst_rdy1",  {31'd0, req1_ready}, 32'd0);
        step();
        step();
        idle_inputs();
        #2;
        reset = 1'b1;
        step();

        // 1: req0 only, one-cycle write pulse.
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_1234; req0_pc = 32'h0000_3000;
        #1;
        check_eq("t1_rdy0", {31'd0, req0_ready}, 32'd1);
        check_eq("t1_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        check_eq("t1_we", {31'd0, gpr_we}, 32'd1);
        check_eq("t1_rw", {27'd0, gpr_rw}, 32'd5);
        check_eq("t1_wd", gpr_wd, 32'h0000_1234);
        check_eq("t1_pc", gpr_pc, 32'h0000_3000);
        step();
        check_eq("t1_we_off", {31'd0, gpr_we}, 32'd0);

        // 2: both valid every cycle, starvation forces every fifth grant to req1.
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1'b1; req0_addr = 5'(i + 1);  req0_data = 32'h100 + 32'(i); req0_pc = 32'h4000 + 32'(i);
            req1_valid = 1'b1; req1_addr = 5'(i + 11); req1_data = 32'h200 + 32'(i); req1_pc = 32'h5000 + 32'(i);
            exp_wd = (exp_g[i] == 1) ? (32'h200 + 32'(i)) : (32'h100 + 32'(i));
            #1;
            check_eq($sformatf("t2_rdy0_%0d", i), {31'd0, req0_ready}, (exp_g[i] == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_rdy1_%0d", i), {31'd0, req1_ready}, (exp_g[i] == 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_onehot_%0d", i), {31'd0, req0_ready & req1_ready}, 32'd0);
            step();
            check_eq($sformatf("t2_glast_%0d", i), {31'd0, grant_last}, 32'(exp_g[i]));
            check_eq($sformatf("t2_wd_%0d", i), gpr_wd, exp_wd);
        end
        idle_inputs();
        step();

        // 3: req1 writing $0: handshake completes, no write, no bypass hit.
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF; req1_pc = 32'h0000_6000;
        #1;
        check_eq("t3_rdy1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        rs_addr = 5'd0;
        #1;
        check_eq("t3_we",     {31'd0, gpr_we},     32'd0);
        check_eq("t3_glast",  {31'd0, grant_last}, 32'd1);
        check_eq("t3_rs_hit", {31'd0, rs_hit},     32'd0);
        check_eq("t3_rs_data", rs_data,            32'd0);
        step();

        // 4: bypass hit on rs, miss on rt.
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_00AA; req0_pc = 32'h0000_7000;
        step();
        req0_valid = 1'b0;
        rs_addr = 5'd7; rt_addr = 5'd8;
        #1;
        check_eq("t4_rs_hit",  {31'd0, rs_hit}, 32'd1);
        check_eq("t4_rs_data", rs_data,         32'h0000_00AA);
        check_eq("t4_rt_hit",  {31'd0, rt_hit}, 32'd0);
        check_eq("t4_rt_data", rt_data,         32'd0);
        rs_addr = 5'd0; rt_addr = 5'd0;
        step();

        // 5: same address from both, req1 starved to the limit wins first.
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h2; req1_pc = 32'h0000_8100;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_addr = 5'(10 + i); req0_data = 32'h300 + 32'(i); req0_pc = 32'h0000_8000;
            #1;
            check_eq($sformatf("t5_lose_%0d", i), {31'd0, req0_ready}, 32'd1);
            step();
        end
        req0_addr = 5'd9; req0_data = 32'h1; req0_pc = 32'h0000_8004;
        #1;
        check_eq("t5_rdy1_first", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        check_eq("t5_wd_first", gpr_wd, 32'h2);
        #1;
        check_eq("t5_rdy0_next", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        check_eq("t5_rw_final", {27'd0, gpr_rw}, 32'd9);
        check_eq("t5_wd_final", gpr_wd, 32'h1);
        check_eq("t5_glast",    {31'd0, grant_last}, 32'd0);
        step();

        // 6: reset mid-stream with a write in flight and counter at 3.
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_addr = 5'(20 + i); req0_data = 32'h400 + 32'(i); req0_pc = 32'h0000_9000;
            req1_valid = 1'b1; req1_addr = 5'd30; req1_data = 32'h0000_0BEE; req1_pc = 32'h0000_9100;
            step();
        end
        check_eq("t6_we_pre", {31'd0, gpr_we}, 32'd1);
        check_eq("t6_cnt_pre", 32'(dut.starve_cnt_r), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_we_rst",   {31'd0, gpr_we},     32'd0);
        check_eq("t6_rdy0_rst", {31'd0, req0_ready}, 32'd0);
        check_eq("t6_rdy1_rst", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_cnt_post", 32'(dut.starve_cnt_r), 32'd0);
        check_eq("t6_rdy1_post", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        check_eq("t6_glast", {31'd0, grant_last}, 32'd1);
        check_eq("t6_we",    {31'd0, gpr_we},     32'd1);
        check_eq("t6_wd",    gpr_wd,              32'h0000_0BEE);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
